bitlet_sched_16: RTL and testbench
==================================

BITLET_SCHED_16 -- requirements
Module: bitlet_sched_16

Interface
REQ-001 Parameters (name, default, meaning): DATA_WIDTH, 8, weight/activation width = number of bit planes; VEC_LENGTH, 16, activations per tile; MUX_SEL_WIDTH, $clog2(VEC_LENGTH), activation mux select width.
REQ-002 Ports (name, direction, width, meaning), clock and reset first:
- clk  in  1  sole clock.
- reset  in  1  synchronous, active-high reset.
- w_in  in  [VEC_LENGTH] x DATA_WIDTH  tile weights.
- w_valid  in  1  tile offered.
- w_ready  out  1  scheduler accepts a tile.
- w_load  in  1  seed the accumulator from accum_prev at tile start; sampled with w_in.
- act_sel  out  [DATA_WIDTH] x MUX_SEL_WIDTH  per-plane activation index to the MAC mux.
- act_val  out  [DATA_WIDTH] x 1  per-plane select valid.
- mac_en  out  1  MAC enable.
- mac_load_accum  out  1  MAC load_accum.
- busy  out  1  tile in flight.
- done  out  1  one-cycle pulse; MAC result holds the final tile sum.

Function
REQ-003 A tile SHALL be accepted on a rising edge where w_valid && w_ready; w_ready SHALL be 1 only in IDLE.
REQ-004 On acceptance, the block SHALL capture plane masks: mask[j][i] = w_in[i][j] for j < DATA_WIDTH and i < VEC_LENGTH, plus w_load.
REQ-005 FSM states SHALL be IDLE, RUN, DRAIN and DONE, with these transitions:
- IDLE -> RUN on acceptance.
- RUN -> DRAIN when all masks are zero after the current cycle's clear.
- DRAIN -> DONE unconditionally.
- DONE -> IDLE unconditionally.
REQ-006 In RUN, for each plane j:
- act_sel[j] = index of the lowest set bit of mask[j];
- act_val[j] = |mask[j];
- that bit SHALL be cleared at the clock edge.
REQ-007 With an all-zero mask, act_sel[j] SHALL be 0 and act_val[j] SHALL be 0.
REQ-008 The RUN length SHALL be N = max over j of popcount(mask[j]), with minimum 1; an all-zero tile runs one RUN cycle with every act_val = 0.
REQ-009 mac_en SHALL be 1 in RUN and DRAIN and 0 otherwise; in DRAIN all act_val SHALL be 0, so the MAC psum register is flushed to 0.
REQ-010 mac_load_accum SHALL be 1 only in the first RUN cycle of a tile whose captured w_load = 1.
REQ-011 Timing, with acceptance edge at cycle 0:
- RUN occupies cycles 1..N;
- DRAIN occupies cycle N+1;
- done = 1 in cycle N+2 only.
REQ-012 busy SHALL be 1 in RUN, DRAIN and DONE.
REQ-013 w_valid and w_in SHALL be ignored outside IDLE; back-to-back tiles SHALL incur exactly one IDLE cycle between DONE and the next RUN.
REQ-014 All outputs SHALL be driven from registered state only; there SHALL be no combinational path from any input to any output.
REQ-015 Plane 7 sign handling belongs to the MAC; the scheduler SHALL treat all planes identically.

Reset
REQ-016 Reset SHALL be synchronous and active-high on reset, sampled at the rising edge of clk, and SHALL take priority over every other event, including mid-tile.
REQ-017 After reset:
- state = IDLE;
- masks and captured w_load = 0;
- w_ready = 1;
- act_sel, act_val, mac_en, mac_load_accum, busy and done = 0.
REQ-018 A reset during RUN or DRAIN SHALL abandon the tile with no done pulse.

Configuration
REQ-019 Macro BITLET_SCHED_CYCLE_CNT_EN: when defined, output cycle_cnt [$clog2(VEC_LENGTH)+1 bits] SHALL exist.
- It SHALL hold the N of the last completed tile.
- It SHALL update in the DONE cycle.
- It SHALL reset to 0.
When the macro is undefined, the port and its counter SHALL be absent and all other behaviour SHALL be identical.

Structure
REQ-020 Package bitlet_pkg SHALL hold the FSM state enum (IDLE, RUN, DRAIN, DONE) and the default DATA_WIDTH and VEC_LENGTH constants.
REQ-021 Sub-module bitlet_penc_16 (lowest-set-bit priority encoder: 16-bit in, 4-bit index, any-set flag) SHALL be instantiated once per plane.

Verification
REQ-022 Release reset -> next cycle: w_ready = 1, busy = 0, done = 0, mac_en = 0, all act_val = 0.
REQ-023 All w_in = 8'h01, w_load = 1 ->
- 16 RUN cycles with act_sel[0] = 0,1,...,15 and act_val[0] = 1;
- act_val[1..7] = 0 throughout;
- mac_load_accum only in cycle 1;
- done in cycle 18.
REQ-024 All w_in = 0 -> one RUN cycle with all act_val = 0, DRAIN in cycle 2, done in cycle 3.
REQ-025 w_in[3] = 8'hFF, w_in[9] = 8'h80, others 0 ->
- cycle 1: all act_sel = 3 and all act_val = 1;
- cycle 2: act_sel[7] = 9, act_val[7] = 1, other act_val = 0;
- done in cycle 4.
REQ-026 Reset asserted in cycle 5 of the REQ-023 tile -> next cycle: IDLE, w_ready = 1, mac_en = 0, no done pulse.
REQ-027 w_valid held high across two tiles -> second acceptance exactly one cycle after the first done; w_in changes while busy have no effect.

Source files
------------

// File: rtl/bitlet_pkg.sv
// Shared types and default geometry for the bitlet scheduler.
package bitlet_pkg;

    localparam int unsigned DEFAULT_DATA_WIDTH = 8;
    localparam int unsigned DEFAULT_VEC_LENGTH = 16;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } sched_state_t;

endpackage

// File: rtl/bitlet_penc_16.sv
// Lowest-set-bit priority encoder: returns the index of the least significant
// set bit (0 when the input is all-zero) plus an any-set flag.
module bitlet_penc_16 #(
    parameter int unsigned WIDTH     = 16,
    parameter int unsigned IDX_WIDTH = $clog2(WIDTH)
) (
    input  logic [WIDTH-1:0]     vec,
    output logic [IDX_WIDTH-1:0] idx,
    output logic                 any_set
);

    logic found;

    always_comb begin
        idx   = '0;
        found = 1'b0;
        for (int unsigned i = 0; i < WIDTH; i++) begin
            if (vec[i] && !found) begin
                idx   = IDX_WIDTH'(i);
                found = 1'b1;
            end
        end
    end

    assign any_set = |vec;

endmodule

// File: rtl/bitlet_sched_16.sv
// Bit-serial weight scheduler: walks each weight bit plane lowest-set-bit first
// and drives the activation mux. Optional cycle_cnt output: BITLET_SCHED_CYCLE_CNT_EN.
module bitlet_sched_16
    import bitlet_pkg::*;
#(
    parameter int unsigned DATA_WIDTH    = DEFAULT_DATA_WIDTH,
    parameter int unsigned VEC_LENGTH    = DEFAULT_VEC_LENGTH,
    parameter int unsigned MUX_SEL_WIDTH = $clog2(VEC_LENGTH)
) (
    input  logic                                clk,
    input  logic                                reset,
    input  logic [VEC_LENGTH*DATA_WIDTH-1:0]    w_in,
    input  logic                                w_valid,
    output logic                                w_ready,
    input  logic                                w_load,
    output logic [DATA_WIDTH*MUX_SEL_WIDTH-1:0] act_sel,
    output logic [DATA_WIDTH-1:0]               act_val,
    output logic                                mac_en,
    output logic                                mac_load_accum,
    output logic                                busy,
    output logic                                done
`ifdef BITLET_SCHED_CYCLE_CNT_EN
    ,
    output logic [$clog2(VEC_LENGTH):0]         cycle_cnt
`endif
);

    sched_state_t state;

    logic [VEC_LENGTH-1:0]    mask     [DATA_WIDTH];
    logic [VEC_LENGTH-1:0]    mask_nxt [DATA_WIDTH];
    logic [MUX_SEL_WIDTH-1:0] penc_idx [DATA_WIDTH];
    logic [DATA_WIDTH-1:0]    penc_any;
    logic                     masks_left;

    for (genvar j = 0; j < DATA_WIDTH; j++) begin : g_plane
        bitlet_penc_16 #(
            .WIDTH     (VEC_LENGTH),
            .IDX_WIDTH (MUX_SEL_WIDTH)
        ) u_penc (
            .vec     (mask[j]),
            .idx     (penc_idx[j]),
            .any_set (penc_any[j])
        );
    end

    // x & (x - 1) drops the lowest set bit, the same one the encoder selects.
    always_comb begin
        masks_left = 1'b0;
        for (int unsigned j = 0; j < DATA_WIDTH; j++) begin
            mask_nxt[j] = mask[j] & (mask[j] - VEC_LENGTH'(1));
            masks_left  = masks_left | (|mask_nxt[j]);
        end
    end

    // Selects decode straight from registered masks and state only.
    always_comb begin
        act_sel = '0;
        act_val = '0;
        for (int unsigned j = 0; j < DATA_WIDTH; j++) begin
            if (state == RUN && penc_any[j]) begin
                act_val[j]                              = 1'b1;
                act_sel[j*MUX_SEL_WIDTH +: MUX_SEL_WIDTH] = penc_idx[j];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state          <= IDLE;
            w_ready        <= 1'b1;
            mac_en         <= 1'b0;
            mac_load_accum <= 1'b0;
            busy           <= 1'b0;
            done           <= 1'b0;
            for (int unsigned j = 0; j < DATA_WIDTH; j++) begin
                mask[j] <= '0;
            end
        end else begin
            case (state)
                IDLE: begin
                    if (w_valid) begin
                        // Transpose: plane j collects bit j of every weight.
                        for (int unsigned j = 0; j < DATA_WIDTH; j++) begin
                            for (int unsigned i = 0; i < VEC_LENGTH; i++) begin
                                mask[j][i] <= w_in[i*DATA_WIDTH + j];
                            end
                        end
                        mac_load_accum <= w_load;
                        w_ready        <= 1'b0;
                        busy           <= 1'b1;
                        mac_en         <= 1'b1;
                        state          <= RUN;
                    end
                end
                RUN: begin
                    mac_load_accum <= 1'b0;
                    for (int unsigned j = 0; j < DATA_WIDTH; j++) begin
                        mask[j] <= mask_nxt[j];
                    end
                    if (!masks_left) begin
                        state <= DRAIN;
                    end
                end
                DRAIN: begin
                    mac_en <= 1'b0;
                    done   <= 1'b1;
                    state  <= DONE;
                end
                DONE: begin
                    done    <= 1'b0;
                    busy    <= 1'b0;
                    w_ready <= 1'b1;
                    state   <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef BITLET_SCHED_CYCLE_CNT_EN
    localparam int unsigned CNT_W = $clog2(VEC_LENGTH) + 1;

    logic [CNT_W-1:0] run_cnt;

    // run_cnt counts RUN cycles; it is published as cycle_cnt on entry to DONE.
    always_ff @(posedge clk) begin
        if (reset) begin
            run_cnt   <= '0;
            cycle_cnt <= '0;
        end else begin
            if (state == IDLE && w_valid) begin
                run_cnt <= '0;
            end else if (state == RUN) begin
                run_cnt <= run_cnt + CNT_W'(1);
            end
            if (state == DRAIN) begin
                cycle_cnt <= run_cnt;
            end
        end
    end
`endif

endmodule

// File: tb/tb_bitlet_sched_16.sv
// Self-checking bench for bitlet_sched_16: an independent tile model pushes
// per-cycle expectations into a queue, popped and compared once per cycle.
module tb_bitlet_sched_16;

    localparam int DW  = 8;
    localparam int VL  = 16;
    localparam int MSW = 4;

    logic              clk = 1'b0;
    logic              reset;
    logic [VL*DW-1:0]  w_in;
    logic              w_valid;
    logic              w_ready;
    logic              w_load;
    logic [DW*MSW-1:0] act_sel;
    logic [DW-1:0]     act_val;
    logic              mac_en;
    logic              mac_load_accum;
    logic              busy;
    logic              done;
`ifdef BITLET_SCHED_CYCLE_CNT_EN
    logic [4:0]        cycle_cnt;
`endif

    bitlet_sched_16 #(
        .DATA_WIDTH (DW),
        .VEC_LENGTH (VL)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .w_in           (w_in),
        .w_valid        (w_valid),
        .w_ready        (w_ready),
        .w_load         (w_load),
        .act_sel        (act_sel),
        .act_val        (act_val),
        .mac_en         (mac_en),
        .mac_load_accum (mac_load_accum),
        .busy           (busy),
        .done           (done)
`ifdef BITLET_SCHED_CYCLE_CNT_EN
        ,
        .cycle_cnt      (cycle_cnt)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [DW*MSW-1:0] sel;
        logic [DW-1:0]     val;
        logic              en;
        logic              ld;
        logic              bsy;
        logic              dn;
        logic              rdy;
        int                n;
    } exp_t;

    exp_t exp_q[$];
    int   total = 0;
    int   bad   = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got=%0h want=%0h at %0t", tag, got, want, $time);
        end
    endtask

    function automatic exp_t idle_exp();
        exp_t e;
        e.sel = '0; e.val = '0; e.en = 1'b0; e.ld = 1'b0;
        e.bsy = 1'b0; e.dn = 1'b0; e.rdy = 1'b1; e.n = 0;
        return e;
    endfunction

    task automatic compare(input exp_t e, input string pfx);
        check({pfx, ".act_sel"}, 64'(act_sel), 64'(e.sel));
        check({pfx, ".act_val"}, 64'(act_val), 64'(e.val));
        check({pfx, ".mac_en"}, 64'(mac_en), 64'(e.en));
        check({pfx, ".mac_load_accum"}, 64'(mac_load_accum), 64'(e.ld));
        check({pfx, ".busy"}, 64'(busy), 64'(e.bsy));
        check({pfx, ".done"}, 64'(done), 64'(e.dn));
        check({pfx, ".w_ready"}, 64'(w_ready), 64'(e.rdy));
`ifdef BITLET_SCHED_CYCLE_CNT_EN
        if (e.dn) check({pfx, ".cycle_cnt"}, 64'(cycle_cnt), 64'(e.n));
`endif
    endtask

    // Reference model: expectations for RUN cycles 1..N, DRAIN, DONE, then IDLE.
    task automatic push_expect(input logic [VL*DW-1:0] w, input logic ld);
        logic [VL-1:0] m [DW];
        int   n = 0;
        exp_t e;
        for (int j = 0; j < DW; j++) begin
            for (int i = 0; i < VL; i++) m[j][i] = w[i*DW + j];
            if ($countones(m[j]) > n) n = $countones(m[j]);
        end
        if (n == 0) n = 1;
        for (int c = 1; c <= n; c++) begin
            e = idle_exp();
            e.rdy = 1'b0; e.bsy = 1'b1; e.en = 1'b1; e.ld = ld && (c == 1); e.n = n;
            for (int j = 0; j < DW; j++) begin
                for (int i = 0; i < VL; i++) begin
                    if (m[j][i]) begin
                        e.sel[j*MSW +: MSW] = 4'(i);
                        e.val[j] = 1'b1;
                        m[j][i] = 1'b0;
                        break;
                    end
                end
            end
            exp_q.push_back(e);
        end
        e = idle_exp(); e.rdy = 1'b0; e.bsy = 1'b1; e.en = 1'b1; e.n = n;
        exp_q.push_back(e);
        e = idle_exp(); e.rdy = 1'b0; e.bsy = 1'b1; e.dn = 1'b1; e.n = n;
        exp_q.push_back(e);
        exp_q.push_back(idle_exp());
    endtask

    // Call at a negedge while IDLE. While busy, w_in/w_load are scrambled to w_busy/~ld
    // and w_valid is held at 'hold'; abort_at > 0 fires reset after that cycle's check.
    task automatic run_tile(input string name, input logic [VL*DW-1:0] w, input logic ld,
                            input logic hold, input logic [VL*DW-1:0] w_busy, input int abort_at);
        exp_t e;
        int   cyc = 1;
        w_in = w; w_load = ld; w_valid = 1'b1;
        @(posedge clk);
        push_expect(w, ld);
        @(negedge clk);
        w_in = w_busy; w_load = ~ld; w_valid = hold;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            compare(e, $sformatf("%s.c%0d", name, cyc));
            if (abort_at == cyc) begin
                exp_q.delete();
                reset = 1'b1; w_valid = 1'b0;
                @(negedge clk);
                reset = 1'b0;
                compare(idle_exp(), {name, ".after_reset"});
                repeat (4) begin
                    @(negedge clk);
                    check({name, ".no_done"}, 64'(done), 64'd0);
                    check({name, ".no_busy"}, 64'(busy), 64'd0);
                end
            end else if (exp_q.size() > 0) begin
                @(negedge clk);
                cyc++;
            end
        end
    endtask

    function automatic logic [VL*DW-1:0] rnd_w();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    logic [VL*DW-1:0] ones, sparse, r1, r2, r3;

    initial begin
        reset = 1'b1; w_valid = 1'b0; w_in = '0; w_load = 1'b0;
        for (int i = 0; i < VL; i++) ones[i*DW +: DW] = 8'h01;
        sparse = '0;
        sparse[3*DW +: DW] = 8'hFF;
        sparse[9*DW +: DW] = 8'h80;

        repeat (3) @(negedge clk);
        compare(idle_exp(), "in_reset");
        reset = 1'b0;
        @(negedge clk);
        compare(idle_exp(), "post_reset");

        run_tile("ones", ones, 1'b1, 1'b0, rnd_w(), 0);
        run_tile("zero", '0, 1'b0, 1'b0, rnd_w(), 0);
        run_tile("sparse", sparse, 1'b0, 1'b0, rnd_w(), 0);
        run_tile("rand0", rnd_w(), 1'b1, 1'b0, rnd_w(), 0);
        run_tile("rand1", rnd_w() & rnd_w() & rnd_w(), 1'b0, 1'b0, rnd_w(), 0);
        run_tile("abort", ones, 1'b1, 1'b0, rnd_w(), 5);

        r1 = rnd_w() & rnd_w();
        r2 = rnd_w();
        r3 = rnd_w();
        run_tile("b2b_a", r1, 1'b0, 1'b1, r2, 0);
        run_tile("b2b_b", r2, 1'b1, 1'b0, r3, 0);
        run_tile("final", ones, 1'b0, 1'b0, '0, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got=timeout want=finish");
        $fatal(1, "simulation timeout");
    end

endmodule
